// File: rtl/vga_frame_reader_if.sv
// Bundles the memory read port, frame selector and video outputs of
// vga_frame_reader. master = the reader, slave = memory/display side.
interface vga_frame_reader_if;
  logic        frame_select;
  logic [17:0] address_b;
  logic [23:0] read_data_b;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;

  modport master (
    input  frame_select, read_data_b,
    output address_b, hsync, vsync, de, red, green, blue, frame_start
  );

  modport slave (
    output frame_select, read_data_b,
    input  address_b, hsync, vsync, de, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator that streams a windowed image out of a two-port memory,
// aligning sync/enable with the memory read latency.
module vga_frame_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int IMG_W        = 300,
  parameter int IMG_H        = 300,
  parameter int IMG_X0       = 170,
  parameter int IMG_Y0       = 90,
  parameter int RAM_BASE     = 90300,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_frame_reader_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PIPE    = READ_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_LO  = HW'(IMG_X0);
  localparam logic [HW-1:0] WX_HI  = HW'(IMG_X0 + IMG_W);
  localparam logic [HW-1:0] WX_END = HW'(IMG_X0 + IMG_W - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_LO  = VW'(IMG_Y0);
  localparam logic [VW-1:0] WY_HI  = VW'(IMG_Y0 + IMG_H);
  localparam logic [VW-1:0] WY_END = VW'(IMG_Y0 + IMG_H - 1);
  localparam logic [17:0]   BASE_RAM = 18'(RAM_BASE);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [17:0]   addr_q, addr_d;
  logic          at_origin, in_win, last_px;
  logic          hs_now, vs_now, de_now;

  logic [PIPE-1:0]         hs_q, vs_q, de_q, fs_q;
  logic [READ_LATENCY-1:0] win_q;
  logic [23:0]             rgb_q;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  always_comb begin
    at_origin = (h_q == '0) && (v_q == '0);
    in_win    = (h_q >= WX_LO) && (h_q < WX_HI) && (v_q >= WY_LO) && (v_q < WY_HI);
    last_px   = (h_q == WX_END) && (v_q == WY_END);
    hs_now    = !((h_q >= HS_LO) && (h_q < HS_HI));
    vs_now    = !((v_q >= VS_LO) && (v_q < VS_HI));
    de_now    = (h_q < H_VIS) && (v_q < V_VIS);
  end

  // The origin reload doubles as the frame-base latch; the last window pixel
  // does not advance so the counter parks on the final address until reload.
  always_comb begin
    addr_d = addr_q;
    if (at_origin)              addr_d = bus.frame_select ? BASE_RAM : '0;
    else if (in_win && !last_px) addr_d = addr_q + 18'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      hs_q   <= '1;
      vs_q   <= '1;
      de_q   <= '0;
      fs_q   <= '0;
      win_q  <= '0;
      rgb_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      hs_q[0]  <= hs_now;
      vs_q[0]  <= vs_now;
      de_q[0]  <= de_now;
      fs_q[0]  <= at_origin;
      win_q[0] <= in_win;
      for (int i = 1; i < PIPE; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
        de_q[i] <= de_q[i-1];
        fs_q[i] <= fs_q[i-1];
      end
      for (int i = 1; i < READ_LATENCY; i++) win_q[i] <= win_q[i-1];
      // rgb_q is the final pipeline stage for the window flag
      rgb_q <= win_q[READ_LATENCY-1] ? bus.read_data_b : '0;
    end
  end

  assign bus.address_b   = addr_q;
  assign bus.hsync       = hs_q[PIPE-1];
  assign bus.vsync       = vs_q[PIPE-1];
  assign bus.de          = de_q[PIPE-1];
  assign bus.frame_start = fs_q[PIPE-1];
  assign bus.red         = rgb_q[23:16];
  assign bus.green       = rgb_q[15:8];
  assign bus.blue        = rgb_q[7:0];

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, 16/96/48: horizontal porch and sync widths; line total H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE, 480: visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, 10/2/33: vertical porch and sync widths; frame total V_TOTAL = 525.
REQ-005 Parameter IMG_W/IMG_H, 300/300: image window size in pixels.
REQ-006 Parameter IMG_X0/IMG_Y0, 170/90: window top-left position in visible coordinates.
REQ-007 Parameter RAM_BASE, 90300: port-B address of the first RAM frame pixel.
REQ-008 Parameter READ_LATENCY, 2: cycles from address_b to valid read_data_b.
REQ-009 clk  input  1  pixel clock; one pixel per cycle.
REQ-010 rst  input  1  reset, synchronous and active-high.
REQ-011 frame_select  input  1  0 = image ROM region (base 0), 1 = RAM region (base RAM_BASE).
REQ-012 address_b  output  18  read address to the memory stage's second port.
REQ-013 read_data_b  input  24  pixel data {R[23:16],G[15:8],B[7:0]}, valid READ_LATENCY cycles after its address.
REQ-014 hsync, vsync  output  1 each  active-low sync.
REQ-015 de  output  1  high during visible area.
REQ-016 red, green, blue  output  8 each  pixel colour.
REQ-017 frame_start  output  1  one-cycle pulse when counters are at (0,0).

Function
REQ-018 h_count SHALL count 0..H_TOTAL-1 and wrap to 0; v_count SHALL increment when h_count wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-019 In-window condition: IMG_X0 <= h_count < IMG_X0+IMG_W and IMG_Y0 <= v_count < IMG_Y0+IMG_H.
REQ-020 Address generation SHALL use a running 18-bit counter (no multiplier): reloaded to the frame base at (0,0) and incremented by 1 after each in-window cycle; address_b equals the counter value.
REQ-021 Frame base SHALL be latched from frame_select only when counters are at (0,0); frame_select changes mid-frame SHALL NOT affect the current frame.
REQ-022 Outside the window, address_b SHALL hold its last value (no spurious increments).
REQ-023 For counter state (h,v) in cycle t: hsync is low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync is low when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; de is high when h < H_ACTIVE and v < V_ACTIVE.
REQ-024 hsync, vsync, de, frame_start and in-window flag SHALL be delayed through a READ_LATENCY+1 stage shift pipeline so all outputs for (h,v) appear registered at cycle t+READ_LATENCY+1 = t+3.
REQ-025 RGB output at t+3 SHALL be read_data_b registered if (h,v) was in-window; 0 if de high but outside window; 0 if de low.
REQ-026 Last window pixel address SHALL be base+IMG_W*IMG_H-1 (89999 for ROM, 180299 for RAM); no address beyond it is issued within a frame.

Reset
REQ-027 While rst is high at a rising clk: h_count=0, v_count=0, address counter=0, latched base=0, all pipeline stages cleared.
REQ-028 Reset outputs: hsync=1, vsync=1, de=0, red=green=blue=0, frame_start=0, address_b=0.
REQ-029 The first cycle after rst deasserts SHALL have counters at (0,0), which latches frame_select as for any frame start; reset mid-frame SHALL abandon the frame with no partial-line output.

Verification
REQ-030 Release reset, run 800 cycles -> hsync low on output cycles 659..754 exactly; de high on output cycles 3..642 (first line, v=0).
REQ-031 Run a full frame -> vsync low for exactly 2*800 cycles starting at output cycle 490*800+3; frame_start pulses once per 420000 cycles.
REQ-032 frame_select=0 -> address_b=0 at (170,90), 299 at (469,90), 300 at (170,91), 89999 at (469,389), then holds 89999 until next frame reload to 0.
REQ-033 frame_select=1 latched at frame start -> address_b=90300 at (170,90), 180299 at (469,389); toggling frame_select at v=200 leaves the current frame's addresses unchanged and takes effect at next (0,0).
REQ-034 Memory model returning data=address-dependent pattern with 2-cycle latency -> red/green/blue at output cycle t+3 match the pattern for address issued at t; pixel (169,90) and (470,90) output 0 with de=1.
REQ-035 Assert rst for 1 cycle at (400,250) -> next cycle outputs match REQ-028, counters restart at (0,0), address_b restarts from new base.
